// File: rtl/enc_frame_scheduler_pkg.sv
// rtl/enc_frame_scheduler_pkg.sv - shared encoder constants and phase enums
package enc_frame_scheduler_pkg;

    localparam int ENC_SYM     = 2;
    localparam int EGF_DIM     = 4;
    localparam int RSC_MES_LEN = 8;

    typedef enum logic [1:0] {PRO_IDLE, PRO_LOAD, PRO_PARITY} pro_phase_t;
    typedef enum logic [1:0] {SEL_IDLE, SEL_MSG, SEL_PAR} sel_phase_t;
    typedef enum logic [1:0] {WAIT_SOF, BUSY, FILL} sch_phase_t;

endpackage

// File: rtl/enc_frame_scheduler_tag.sv
// rtl/enc_frame_scheduler_tag.sv - sch_tag_delay: beat-enabled codeword tag delay line
module sch_tag_delay #(
    parameter int DEPTH = 3,
    parameter int OW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          in_valid,
    input  logic [OW-1:0] in_owner,
    input  logic          in_fill,
    output logic          out_valid,
    output logic [OW-1:0] out_owner,
    output logic          out_fill
);

    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] fil;
    logic [OW-1:0]    own [DEPTH];
    logic             fresh;

    logic [DEPTH-1:0] sh_v;
    logic [DEPTH-1:0] sh_f;
    logic [OW-1:0]    sh_o [DEPTH];

    always_comb begin
        sh_v    = '0;
        sh_f    = '0;
        sh_v[0] = in_valid;
        sh_f[0] = in_fill;
        sh_o[0] = in_owner;
        for (int i = 1; i < DEPTH; i++) begin
            sh_v[i] = vld[i-1];
            sh_f[i] = fil[i-1];
            sh_o[i] = own[i-1];
        end
    end

    // The last stage keeps owner/fill until a new tag lands so they hold between starts.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld   <= '0;
            fil   <= '0;
            fresh <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                own[i] <= '0;
            end
        end else begin
            fresh <= en;
            if (en) begin
                vld <= sh_v;
                for (int i = 0; i < DEPTH; i++) begin
                    if (i < DEPTH - 1 || sh_v[i]) begin
                        own[i] <= sh_o[i];
                        fil[i] <= sh_f[i];
                    end
                end
            end
        end
    end

    // fresh suppresses a repeat pulse while a stall holds the last stage.
    assign out_valid = vld[DEPTH-1] & fresh;
    assign out_owner = own[DEPTH-1];
    assign out_fill  = fil[DEPTH-1];

endmodule

// File: rtl/enc_frame_scheduler.sv
// rtl/enc_frame_scheduler.sv - round-robin frame scheduler feeding one shared encoder
module enc_frame_scheduler
    import enc_frame_scheduler_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int MES_BEATS = RSC_MES_LEN / ENC_SYM,
    parameter int ENC_LAT   = 3
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ*ENC_SYM*EGF_DIM-1:0]  req_data,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic                                enc_stall,
    input  logic                                enc_sof,
    output logic [ENC_SYM*EGF_DIM-1:0]          gen_data,
    output logic                                cw_start,
    output logic [$clog2(NUM_REQ)-1:0]          cw_owner,
    output logic                                cw_fill,
    output logic                                underrun,
    output logic                                sync_err
);

    localparam int BW = ENC_SYM * EGF_DIM;
    localparam int OW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MES_BEATS + 1);

    sch_phase_t    state_q, state_d;
    logic [CW-1:0] beat_cnt, cnt_d;
    logic [OW-1:0] rr_ptr, rr_d;
    logic [OW-1:0] owner, owner_d;
    logic          underrun_d, sync_err_d;
    logic          accept, start;
    logic          found;
    logic [OW-1:0] gnt;
    int            cand;
    logic          tag_valid, tag_fill;
    logic [OW-1:0] tag_owner;
    logic [BW-1:0] req_beat [NUM_REQ];

    assign accept = ~enc_stall;
    assign start  = accept & enc_sof;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_beat[i] = req_data[i*BW +: BW];
        end
    end

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        cand  = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && req_valid[OW'(cand)]) begin
                found = 1'b1;
                gnt   = OW'(cand);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = beat_cnt;
        rr_d       = rr_ptr;
        owner_d    = owner;
        req_ready  = '0;
        gen_data   = '0;
        underrun_d = 1'b0;
        sync_err_d = 1'b0;
        tag_valid  = 1'b0;
        tag_owner  = '0;
        tag_fill   = 1'b0;
        if (start) begin
            // A sof mid-frame abandons the current frame and arbitrates afresh.
            sync_err_d = (state_q != WAIT_SOF);
            tag_valid  = 1'b1;
            cnt_d      = CW'(1);
            if (found) begin
                state_d        = BUSY;
                req_ready[gnt] = 1'b1;
                gen_data       = req_beat[gnt];
                rr_d           = gnt;
                owner_d        = gnt;
                tag_owner      = gnt;
            end else begin
                state_d  = FILL;
                tag_fill = 1'b1;
            end
        end else if (accept && state_q != WAIT_SOF) begin
            cnt_d = beat_cnt + CW'(1);
            if (state_q == BUSY) begin
                req_ready[owner] = 1'b1;
                if (req_valid[owner]) begin
                    gen_data = req_beat[owner];
                end else begin
                    underrun_d = 1'b1;
                end
            end
        end
        if (accept && state_d != WAIT_SOF && cnt_d == CW'(MES_BEATS)) begin
            state_d = WAIT_SOF;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= WAIT_SOF;
            beat_cnt <= '0;
            rr_ptr   <= OW'(NUM_REQ - 1);
            owner    <= '0;
            underrun <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            state_q  <= state_d;
            beat_cnt <= cnt_d;
            rr_ptr   <= rr_d;
            owner    <= owner_d;
            underrun <= underrun_d;
            sync_err <= sync_err_d;
        end
    end

    sch_tag_delay #(
        .DEPTH (ENC_LAT),
        .OW    (OW)
    ) u_tag_delay (
        .clk       (clk),
        .rst       (rst),
        .en        (accept),
        .in_valid  (tag_valid),
        .in_owner  (tag_owner),
        .in_fill   (tag_fill),
        .out_valid (cw_start),
        .out_owner (cw_owner),
        .out_fill  (cw_fill)
    );

endmodule

// File: tb/tb_enc_frame_scheduler.sv
// tb/tb_enc_frame_scheduler.sv - scoreboard bench for enc_frame_scheduler
module tb_enc_frame_scheduler;
    import enc_frame_scheduler_pkg::*;

    localparam int NR  = 4;
    localparam int MB  = 4;
    localparam int LAT = 3;
    localparam int BW  = ENC_SYM * EGF_DIM;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR-1:0]     req_valid = '0;
    logic [NR*BW-1:0]  req_data = '0;
    logic [NR-1:0]     req_ready;
    logic              enc_stall = 1'b0;
    logic              enc_sof = 1'b0;
    logic [BW-1:0]     gen_data;
    logic              cw_start;
    logic [1:0]        cw_owner;
    logic              cw_fill;
    logic              underrun;
    logic              sync_err;

    always #5 clk = ~clk;

    enc_frame_scheduler #(
        .NUM_REQ   (NR),
        .MES_BEATS (MB),
        .ENC_LAT   (LAT)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .enc_stall (enc_stall),
        .enc_sof   (enc_sof),
        .gen_data  (gen_data),
        .cw_start  (cw_start),
        .cw_owner  (cw_owner),
        .cw_fill   (cw_fill),
        .underrun  (underrun),
        .sync_err  (sync_err)
    );

    typedef struct packed {
        logic [31:0] due;
        logic [1:0]  owner;
        logic        fill;
    } cw_exp_t;

    cw_exp_t     sb[$];
    int          checks = 0;
    int          failures = 0;
    int          acc = 0;
    logic        last_acc = 1'b0;
    logic        exp_underrun = 1'b0;
    logic        exp_sync = 1'b0;
    logic [1:0]  tb_rr = 2'd3;
    logic [1:0]  tb_owner = 2'd0;
    logic        tb_fill = 1'b0;
    int          tb_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Accepted-edge counter; cw_start due times are measured against it.
    initial begin
        forever begin
            @(posedge clk);
            if (!rst) begin
                if (!enc_stall) acc++;
                last_acc = !enc_stall;
            end
        end
    end

    initial begin
        cw_exp_t e;
        logic    exp_cs;
        forever begin
            @(posedge clk);
            #2;
            if (!rst) begin
                exp_cs = (sb.size() > 0) && (sb[0].due == 32'(acc)) && last_acc;
                check_eq("cw_start", cw_start, exp_cs);
                if (exp_cs) begin
                    e = sb.pop_front();
                    check_eq("cw_owner", cw_owner, e.owner);
                    check_eq("cw_fill", cw_fill, e.fill);
                end
                check_eq("underrun", underrun, exp_underrun);
                check_eq("sync_err", sync_err, exp_sync);
            end
        end
    end

    task automatic drive(input logic sof, input logic stall, input logic [NR-1:0] vld);
        logic [NR-1:0] exp_ready;
        logic [BW-1:0] exp_gen;
        logic          nxt_underrun;
        logic          nxt_sync;
        logic          found;
        logic [1:0]    g;
        logic [1:0]    idx;
        cw_exp_t       e;
        @(negedge clk);
        enc_sof   = sof;
        enc_stall = stall;
        req_valid = vld;
        req_data  = $urandom;
        exp_ready = '0;
        exp_gen   = '0;
        nxt_underrun = 1'b0;
        nxt_sync  = 1'b0;
        found     = 1'b0;
        g         = '0;
        if (!stall) begin
            if (sof) begin
                nxt_sync = (tb_cnt != 0);
                for (int k = 1; k <= NR; k++) begin
                    idx = 2'((int'(tb_rr) + k) % NR);
                    if (!found && vld[idx]) begin
                        found = 1'b1;
                        g     = idx;
                    end
                end
                if (found) begin
                    exp_ready[g] = 1'b1;
                    exp_gen      = req_data[g*BW +: BW];
                    tb_rr        = g;
                    tb_owner     = g;
                end
                tb_fill = !found;
                e.due   = 32'(acc + LAT);
                e.owner = found ? g : 2'd0;
                e.fill  = !found;
                sb.push_back(e);
                tb_cnt = 1;
            end else if (tb_cnt != 0) begin
                if (!tb_fill) begin
                    exp_ready[tb_owner] = 1'b1;
                    if (vld[tb_owner]) exp_gen = req_data[tb_owner*BW +: BW];
                    else nxt_underrun = 1'b1;
                end
                tb_cnt++;
            end
            if (tb_cnt == MB) tb_cnt = 0;
        end
        #1;
        check_eq("req_ready", req_ready, exp_ready);
        check_eq("gen_data", gen_data, exp_gen);
        @(posedge clk);
        exp_underrun = nxt_underrun;
        exp_sync     = nxt_sync;
    endtask

    task automatic frame(input logic [NR-1:0] vld);
        drive(1'b1, 1'b0, vld);
        for (int b = 1; b < MB; b++) drive(1'b0, 1'b0, vld);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        enc_sof   = 1'b0;
        enc_stall = 1'b0;
        req_valid = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_cw_start", cw_start, 0);
        check_eq("rst_cw_owner", cw_owner, 0);
        check_eq("rst_cw_fill", cw_fill, 0);
        check_eq("rst_underrun", underrun, 0);
        check_eq("rst_sync_err", sync_err, 0);
        check_eq("rst_rr_ptr", u_dut.rr_ptr, NR - 1);
        sb.delete();
        tb_rr        = 2'd3;
        tb_cnt       = 0;
        tb_owner     = 2'd0;
        tb_fill      = 1'b0;
        exp_underrun = 1'b0;
        exp_sync     = 1'b0;
        last_acc     = 1'b0;
        rst          = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        do_reset();
        drive(1'b0, 1'b0, 4'b1111);
        drive(1'b0, 1'b0, 4'b1111);

        // all requesters valid: grants rotate 0,1,2,3,0
        for (int f = 0; f < 5; f++) frame(4'b1111);

        // only requester 2 valid
        for (int f = 0; f < 3; f++) begin
            frame(4'b0100);
            check_eq("rr_ptr_req2", u_dut.rr_ptr, 2);
        end

        // nobody valid: filler frame
        frame(4'b0000);
        check_eq("rr_ptr_fill", u_dut.rr_ptr, 2);

        // requester 1 drops valid on beat 3
        drive(1'b1, 1'b0, 4'b0010);
        drive(1'b0, 1'b0, 4'b0010);
        drive(1'b0, 1'b0, 4'b0000);
        drive(1'b0, 1'b0, 4'b0010);
        drive(1'b0, 1'b0, 4'b1111);

        // five stall cycles mid-frame
        drive(1'b1, 1'b0, 4'b1111);
        drive(1'b0, 1'b0, 4'b1111);
        for (int s = 0; s < 5; s++) drive(1'b0, 1'b1, 4'b1111);
        drive(1'b0, 1'b0, 4'b1111);
        drive(1'b0, 1'b0, 4'b1111);

        // sof at beat_cnt=2
        drive(1'b1, 1'b0, 4'b1111);
        drive(1'b0, 1'b0, 4'b1111);
        frame(4'b1111);
        for (int i = 0; i < LAT; i++) drive(1'b0, 1'b0, 4'b1111);

        // reset mid-frame drops the pending codeword
        drive(1'b1, 1'b0, 4'b1111);
        drive(1'b0, 1'b0, 4'b1111);
        do_reset();
        for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 4'b1111);
        frame(4'b1111);
        for (int i = 0; i < LAT + 1; i++) drive(1'b0, 1'b0, 4'b0000);

        check_eq("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
